// File: rtl/condicionador_botoes_pkg.sv
// -----------------------------------------------------------------------------
// condicionador_botoes_pkg
// Shared definitions for the button conditioner:
//   NUM_BOTOES     - number of physical buttons (7)
//   CODIGO_NENHUM  - note code meaning "no play since reset"
//   estado_t       - play-decision FSM states
//   conta_altos()  - number of high bits in a button vector
//   codigo_de()    - note code (index + 1) of the high bit of a one-hot vector
// -----------------------------------------------------------------------------
package condicionador_botoes_pkg;

  localparam int          NUM_BOTOES    = 7;
  localparam logic [2:0]  CODIGO_NENHUM = 3'd0;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    ACEITA  = 2'd1,
    REJEITA = 2'd2,
    SEGURA  = 2'd3
  } estado_t;

  // Seven bits can never have more than 7 high, so 3 bits hold the count.
  function automatic logic [2:0] conta_altos(input logic [NUM_BOTOES-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < NUM_BOTOES; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  // Only meaningful for a one-hot vector; an all-zero vector yields CODIGO_NENHUM.
  function automatic logic [2:0] codigo_de(input logic [NUM_BOTOES-1:0] v);
    logic [2:0] c;
    c = CODIGO_NENHUM;
    for (int i = 0; i < NUM_BOTOES; i++) begin
      if (v[i]) begin
        c = 3'(i + 1);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// -----------------------------------------------------------------------------
// condicionador_botoes_if
// Bundles the button conditioner's data signals.
//   botoes                 - raw asynchronous button levels (driven by master)
//   botoes_limpos          - synchronized, debounced levels
//   jogada / codigo        - one-hot and note code of the last accepted play
//   tem_botao_pressionado  - any debounced button high
//   tem_jogada             - one-cycle pulse on an accepted play
//   erro_multiplo          - one-cycle pulse on a rejected multi-button press
//   db_num_jogadas         - debug count of accepted plays
// Modports: master (button source / observer), slave (the conditioner).
// -----------------------------------------------------------------------------
interface condicionador_botoes_if;
  import condicionador_botoes_pkg::*;

  logic [NUM_BOTOES-1:0] botoes;
  logic [NUM_BOTOES-1:0] botoes_limpos;
  logic [NUM_BOTOES-1:0] jogada;
  logic [2:0]            codigo;
  logic                  tem_botao_pressionado;
  logic                  tem_jogada;
  logic                  erro_multiplo;
  logic [7:0]            db_num_jogadas;

  modport master (
    output botoes,
    input  botoes_limpos,
    input  jogada,
    input  codigo,
    input  tem_botao_pressionado,
    input  tem_jogada,
    input  erro_multiplo,
    input  db_num_jogadas
  );

  modport slave (
    input  botoes,
    output botoes_limpos,
    output jogada,
    output codigo,
    output tem_botao_pressionado,
    output tem_jogada,
    output erro_multiplo,
    output db_num_jogadas
  );

endinterface

// File: rtl/condicionador_botoes_debouncer_botao.sv
// -----------------------------------------------------------------------------
// debouncer_botao
// Single-bit two-flop synchronizer followed by a stability counter.
//   clock    - rising-edge clock
//   reset    - asynchronous active-high reset (clears flops and counter)
//   entrada  - raw asynchronous level
//   limpo    - debounced level; flips the cycle after the synchronized input
//              has disagreed with it for DEBOUNCE_CYCLES consecutive cycles
// -----------------------------------------------------------------------------
module debouncer_botao #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic limpo
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; legal range keeps CW >= 1.
  localparam int             CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CONT_FIM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sinc1_r;
  logic          sinc2_r;
  logic          limpo_r;
  logic [CW-1:0] cont_r;

  logic          limpo_nxt_s;
  logic [CW-1:0] cont_nxt_s;

  // Two-flop synchronizer for the raw button level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1_r <= 1'b0;
      sinc2_r <= 1'b0;
    end else begin
      sinc1_r <= entrada;
      sinc2_r <= sinc1_r;
    end
  end

  // Count consecutive disagreeing cycles; the last one flips the clean level.
  always_comb begin
    limpo_nxt_s = limpo_r;
    cont_nxt_s  = '0;
    if (sinc2_r != limpo_r) begin
      if (cont_r == CONT_FIM) begin
        limpo_nxt_s = sinc2_r;
        cont_nxt_s  = '0;
      end else begin
        limpo_nxt_s = limpo_r;
        cont_nxt_s  = cont_r + CW'(1);
      end
    end else begin
      // Any agreement restarts the stability window.
      cont_nxt_s = '0;
    end
  end

  // Debounce state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont_r  <= '0;
      limpo_r <= 1'b0;
    end else begin
      cont_r  <= cont_nxt_s;
      limpo_r <= limpo_nxt_s;
    end
  end

  assign limpo = limpo_r;

endmodule

// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
// Conditions seven raw buttons into debounced levels and single-button plays.
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - condicionador_botoes_if.slave: botoes in; botoes_limpos, jogada,
//            codigo, tem_botao_pressionado, tem_jogada, erro_multiplo,
//            db_num_jogadas out
// Parameter DEBOUNCE_CYCLES: stable cycles needed to accept a level change.
// Optional macro CONDICIONADOR_BOTOES_CONTADOR_EN: enables the 8-bit wrapping
// play counter on db_num_jogadas (otherwise it is tied to zero).
// -----------------------------------------------------------------------------
module condicionador_botoes
  import condicionador_botoes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  condicionador_botoes_if.slave bus
);

  logic [NUM_BOTOES-1:0] limpos_s;

  estado_t               estado_r;
  estado_t               estado_nxt_s;
  logic [NUM_BOTOES-1:0] jogada_r;
  logic [NUM_BOTOES-1:0] jogada_nxt_s;
  logic [2:0]            codigo_r;
  logic [2:0]            codigo_nxt_s;
  logic                  tem_jogada_r;
  logic                  tem_jogada_nxt_s;
  logic                  erro_r;
  logic                  erro_nxt_s;
  logic [2:0]            n_altos_s;

  genvar g;
  generate
    for (g = 0; g < NUM_BOTOES; g++) begin : g_debounce
      debouncer_botao #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clock   (clock),
        .reset   (reset),
        .entrada (bus.botoes[g]),
        .limpo   (limpos_s[g])
      );
    end
  endgenerate

  // Next-state and next-output logic of the play-decision FSM.
  // The ACEITA/REJEITA outputs are computed on the edge entering those states
  // so the pulse is registered and coincides with the state itself.
  always_comb begin
    estado_nxt_s     = estado_r;
    jogada_nxt_s     = jogada_r;
    codigo_nxt_s     = codigo_r;
    tem_jogada_nxt_s = 1'b0;
    erro_nxt_s       = 1'b0;
    n_altos_s        = conta_altos(limpos_s);
    case (estado_r)
      ESPERA: begin
        if (n_altos_s == 3'd1) begin
          estado_nxt_s     = ACEITA;
          jogada_nxt_s     = limpos_s;
          codigo_nxt_s     = codigo_de(limpos_s);
          tem_jogada_nxt_s = 1'b1;
        end else if (n_altos_s != 3'd0) begin
          estado_nxt_s = REJEITA;
          erro_nxt_s   = 1'b1;
        end else begin
          estado_nxt_s = ESPERA;
        end
      end
      ACEITA: begin
        estado_nxt_s = SEGURA;
      end
      REJEITA: begin
        estado_nxt_s = SEGURA;
      end
      SEGURA: begin
        // Anything pressed here belongs to the press already handled.
        if (limpos_s == {NUM_BOTOES{1'b0}}) begin
          estado_nxt_s = ESPERA;
        end else begin
          estado_nxt_s = SEGURA;
        end
      end
      default: begin
        estado_nxt_s = ESPERA;
      end
    endcase
  end

  // FSM state and registered play outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_r     <= ESPERA;
      jogada_r     <= {NUM_BOTOES{1'b0}};
      codigo_r     <= CODIGO_NENHUM;
      tem_jogada_r <= 1'b0;
      erro_r       <= 1'b0;
    end else begin
      estado_r     <= estado_nxt_s;
      jogada_r     <= jogada_nxt_s;
      codigo_r     <= codigo_nxt_s;
      tem_jogada_r <= tem_jogada_nxt_s;
      erro_r       <= erro_nxt_s;
    end
  end

`ifdef CONDICIONADOR_BOTOES_CONTADOR_EN
  logic [7:0] num_jogadas_r;

  // Play counter; steps on the same edge that raises tem_jogada, wraps at 255.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      num_jogadas_r <= 8'd0;
    end else if (tem_jogada_nxt_s) begin
      num_jogadas_r <= num_jogadas_r + 8'd1;
    end else begin
      num_jogadas_r <= num_jogadas_r;
    end
  end

  assign bus.db_num_jogadas = num_jogadas_r;
`else
  assign bus.db_num_jogadas = 8'd0;
`endif

  assign bus.botoes_limpos         = limpos_s;
  assign bus.tem_botao_pressionado = |limpos_s;
  assign bus.jogada                = jogada_r;
  assign bus.codigo                = codigo_r;
  assign bus.tem_jogada            = tem_jogada_r;
  assign bus.erro_multiplo         = erro_r;

endmodule

// File: tb/tb_condicionador_botoes.sv
// -----------------------------------------------------------------------------
// tb_condicionador_botoes
// Self-checking bench for condicionador_botoes with DEBOUNCE_CYCLES = 4.
// A reference model describes debounce as "the last N synchronized samples
// all disagree with the clean level" and play decisions as "the first non-zero
// clean vector after an all-zero one", and is compared every cycle.
// -----------------------------------------------------------------------------
module tb_condicionador_botoes;
  import condicionador_botoes_pkg::*;

  localparam int N = 4;

`ifdef CONDICIONADOR_BOTOES_CONTADOR_EN
  localparam logic [7:0] DB_APOS_255 = 8'd255;
`else
  localparam logic [7:0] DB_APOS_255 = 8'd0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  condicionador_botoes_if bus ();

  condicionador_botoes #(
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Observed-event accumulators, cleared per scenario.
  int              n_tj = 0;
  int              n_err = 0;
  logic [6:0]      limpos_vistos = 7'd0;

  // Reference model state.
  logic [6:0] m_s1, m_s2, m_clean, m_jog;
  logic [6:0] m_hist[$];
  logic [2:0] m_cod;
  logic       m_tj, m_err, m_idle;
  logic [7:0] m_db;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 7'd0; m_s2 = 7'd0; m_clean = 7'd0; m_jog = 7'd0;
    m_hist.delete();
    m_cod = 3'd0; m_tj = 1'b0; m_err = 1'b0; m_idle = 1'b1; m_db = 8'd0;
  endtask

  // Advance the model over one rising edge whose sampled raw input is raw.
  task automatic model_step(input logic [6:0] raw);
    logic [6:0] amostra;
    logic [6:0] novo;
    int         cont;
    m_tj  = 1'b0;
    m_err = 1'b0;
    if (m_idle && (m_clean != 7'd0)) begin
      m_idle = 1'b0;
      if ($countones(m_clean) == 1) begin
        m_tj  = 1'b1;
        m_jog = m_clean;
        for (int i = 0; i < NUM_BOTOES; i++) begin
          if (m_clean[i]) m_cod = 3'(i + 1);
        end
`ifdef CONDICIONADOR_BOTOES_CONTADOR_EN
        m_db = m_db + 8'd1;
`endif
      end else begin
        m_err = 1'b1;
      end
    end else if (!m_idle && (m_clean == 7'd0)) begin
      m_idle = 1'b1;
    end
    m_hist.push_back(m_s2);
    if (m_hist.size() > N) void'(m_hist.pop_front());
    novo = m_clean;
    if (m_hist.size() == N) begin
      for (int i = 0; i < NUM_BOTOES; i++) begin
        cont = 0;
        for (int k = 0; k < N; k++) begin
          amostra = m_hist[k];
          if (amostra[i] != m_clean[i]) cont++;
        end
        if (cont == N) novo[i] = ~m_clean[i];
      end
    end
    m_clean = novo;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  // One cycle: check the DUT at the falling edge, then drive the next inputs.
  task automatic tick(input logic [6:0] raw, input logic rst);
    @(negedge clock);
    verifica("botoes_limpos", 32'(bus.botoes_limpos), 32'(m_clean));
    verifica("jogada", 32'(bus.jogada), 32'(m_jog));
    verifica("codigo", 32'(bus.codigo), 32'(m_cod));
    verifica("tem_botao_pressionado", 32'(bus.tem_botao_pressionado), 32'(|m_clean));
    verifica("tem_jogada", 32'(bus.tem_jogada), 32'(m_tj));
    verifica("erro_multiplo", 32'(bus.erro_multiplo), 32'(m_err));
    verifica("db_num_jogadas", 32'(bus.db_num_jogadas), 32'(m_db));
    verifica("pulsos_exclusivos", 32'(bus.tem_jogada & bus.erro_multiplo), 32'd0);
    n_tj  += int'(bus.tem_jogada);
    n_err += int'(bus.erro_multiplo);
    limpos_vistos |= bus.botoes_limpos;
    if (rst) begin
      reset = 1'b1;
      model_reset();
    end else begin
      reset = 1'b0;
      model_step(raw);
    end
    bus.botoes = raw;
  endtask

  task automatic zera_contagem();
    n_tj = 0;
    n_err = 0;
    limpos_vistos = 7'd0;
  endtask

  initial begin
    int         kind;
    int         len;
    int         rel;
    logic [6:0] v;

    bus.botoes = 7'd0;
    model_reset();

    // Reset state, then release.
    repeat (3) tick(7'd0, 1'b1);
    repeat (4) tick(7'd0, 1'b0);

    // Single stable button -> exactly one play with code 3.
    zera_contagem();
    repeat (12) tick(7'b0000100, 1'b0);
    verifica("p1_pulsos", n_tj, 1);
    verifica("p1_jogada", 32'(bus.jogada), 32'h04);
    verifica("p1_codigo", 32'(bus.codigo), 32'd3);
    repeat (12) tick(7'd0, 1'b0);

    // Bounce on bit 0 shorter than the window never gets through.
    zera_contagem();
    for (int k = 0; k < 40; k++) tick(((k / 2) % 2 == 1) ? 7'b0000001 : 7'b0000000, 1'b0);
    repeat (8) tick(7'd0, 1'b0);
    verifica("p2_limpos", 32'(limpos_vistos), 32'd0);
    verifica("p2_pulsos", n_tj, 0);
    verifica("p2_erros", n_err, 0);

    // Two buttons together -> one rejection, code unchanged.
    zera_contagem();
    repeat (12) tick(7'b0100010, 1'b0);
    repeat (12) tick(7'd0, 1'b0);
    verifica("p3_erros", n_err, 1);
    verifica("p3_pulsos", n_tj, 0);
    verifica("p3_codigo", 32'(bus.codigo), 32'd3);

    // Hold bit 6, add bit 0 while held -> single play code 7, no error.
    zera_contagem();
    repeat (10) tick(7'b1000000, 1'b0);
    repeat (10) tick(7'b1000001, 1'b0);
    repeat (12) tick(7'd0, 1'b0);
    verifica("p4_pulsos", n_tj, 1);
    verifica("p4_erros", n_err, 0);
    verifica("p4_codigo", 32'(bus.codigo), 32'd7);
    verifica("p4_jogada", 32'(bus.jogada), 32'h40);

    // Reset in mid-debounce with bit 3 held; re-debounced after release.
    zera_contagem();
    repeat (4) tick(7'b0001000, 1'b0);
    tick(7'b0001000, 1'b1);
    #1;
    verifica("p5_rst_limpos", 32'(bus.botoes_limpos), 32'd0);
    verifica("p5_rst_jogada", 32'(bus.jogada), 32'd0);
    verifica("p5_rst_codigo", 32'(bus.codigo), 32'd0);
    verifica("p5_rst_pressionado", 32'(bus.tem_botao_pressionado), 32'd0);
    verifica("p5_rst_pulsos", 32'(bus.tem_jogada | bus.erro_multiplo), 32'd0);
    verifica("p5_rst_db", 32'(bus.db_num_jogadas), 32'd0);
    repeat (2) tick(7'b0001000, 1'b1);
    zera_contagem();
    repeat (14) tick(7'b0001000, 1'b0);
    verifica("p5_pulsos", n_tj, 1);
    verifica("p5_codigo", 32'(bus.codigo), 32'd4);
    repeat (12) tick(7'd0, 1'b0);

    // Randomized episodes: single presses, arbitrary vectors and noise.
    for (int ep = 0; ep < 80; ep++) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(1, 14);
      rel  = $urandom_range(1, 14);
      if (kind == 0) begin
        v = 7'(1 << $urandom_range(0, 6));
        repeat (len) tick(v, 1'b0);
        repeat (rel) tick(7'd0, 1'b0);
      end else if (kind == 1) begin
        v = 7'($urandom);
        repeat (len) tick(v, 1'b0);
        repeat (rel) tick(7'd0, 1'b0);
      end else begin
        repeat (len) tick(7'($urandom), 1'b0);
      end
    end
    repeat (16) tick(7'd0, 1'b0);

    // 256 single presses from reset: counter wraps back to 0.
    repeat (2) tick(7'd0, 1'b1);
    zera_contagem();
    for (int p = 0; p < 256; p++) begin
      v = 7'(1 << $urandom_range(0, 6));
      repeat (8) tick(v, 1'b0);
      repeat (8) tick(7'd0, 1'b0);
      if (p == 254) verifica("p6_db_255", 32'(bus.db_num_jogadas), 32'(DB_APOS_255));
    end
    verifica("p6_pulsos", n_tj, 256);
    verifica("p6_db_wrap", 32'(bus.db_num_jogadas), 32'd0);
    tick(7'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive stable cycles needed to accept a level change (1 ms at 50 MHz; legal range 2..2^20).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port botoes, input, 7, raw asynchronous button levels, active-high.
REQ-005 SHALL have port botoes_limpos, output, 7, synchronized and debounced button levels.
REQ-006 SHALL have port jogada, output, 7, registered one-hot of the last accepted play.
REQ-007 SHALL have port codigo, output, 3, note code of the last accepted play: 1..7 for bit 0..6; 0 means no play since reset.
REQ-008 SHALL have port tem_botao_pressionado, output, 1, high while any botoes_limpos bit is high.
REQ-009 SHALL have port tem_jogada, output, 1, one-cycle pulse when a play is accepted.
REQ-010 SHALL have port erro_multiplo, output, 1, one-cycle pulse when a press is rejected for having more than one button high.
REQ-011 SHALL have port db_num_jogadas, output, 8, count of accepted plays (see Configuration).

Function
REQ-012 SHALL pass each botoes bit through a two-flop synchronizer before debounce.
REQ-013 SHALL change a botoes_limpos bit on the cycle after its synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any intermediate agreement restarts that bit's count at 0.
REQ-014 SHALL implement FSM states ESPERA, ACEITA, REJEITA, SEGURA.
REQ-015 ESPERA: exactly one botoes_limpos bit high -> ACEITA; two or more high -> REJEITA; none high -> stay.
REQ-016 ACEITA: SHALL load jogada with botoes_limpos, load codigo with index+1, pulse tem_jogada for exactly one cycle, then go to SEGURA.
REQ-017 REJEITA: SHALL pulse erro_multiplo for one cycle, leave jogada/codigo unchanged, then go to SEGURA.
REQ-018 SEGURA: SHALL stay until botoes_limpos is all zero, then go to ESPERA; buttons added or changed while in SEGURA SHALL NOT create a play.
REQ-019 Latency: tem_jogada SHALL assert exactly 1 cycle after the cycle in which botoes_limpos first shows one button.
REQ-020 tem_botao_pressionado SHALL be combinational OR of botoes_limpos.
REQ-021 tem_jogada and erro_multiplo SHALL never be high in the same cycle.

Reset
REQ-022 On reset asserted: synchronizers, debounce counters, botoes_limpos, jogada, codigo, tem_jogada, erro_multiplo and db_num_jogadas SHALL go to 0 and FSM to ESPERA immediately.
REQ-023 A button held through reset release SHALL be re-debounced from zero and, if alone, accepted as a new play.

Configuration
REQ-024 With CONDICIONADOR_BOTOES_CONTADOR_EN defined, db_num_jogadas SHALL increment by 1 on each tem_jogada pulse, wrapping 255 -> 0.
REQ-025 Without CONDICIONADOR_BOTOES_CONTADOR_EN, db_num_jogadas SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
REQ-026 Shared package SHALL hold the FSM state enumeration, NUM_BOTOES = 7 and CODIGO_NENHUM = 3'd0.
REQ-027 One sub-module, debouncer_botao (synchronizer plus counter for a single bit), SHALL be instantiated 7 times.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 The bench SHALL hold botoes = 7'b0000100 stable. Required: tem_jogada pulses once, jogada = 0000100 and codigo = 3.
REQ-029 The bench SHALL toggle bit 0 every 2 cycles for 40 cycles. Required: botoes_limpos stays 0 and no pulses occur.
REQ-030 The bench SHALL raise bits 1 and 5 together. Required: erro_multiplo pulses once and codigo stays at its previous value.
REQ-031 The bench SHALL hold bit 6, then add bit 0 while bit 6 is held, then release both. Required: one play with codigo = 7 and no erro_multiplo pulse.
REQ-032 The bench SHALL assert reset mid-debounce while bit 3 is held, then release reset. Required: all outputs read 0 during reset; after release, one play with codigo = 4.
REQ-033 The bench SHALL make 256 single presses with CONDICIONADOR_BOTOES_CONTADOR_EN defined. Required: db_num_jogadas wraps to 0; without the macro it reads 0 throughout.
